// File: rtl/latch_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | latch_ctrl_pkg : shared types for the latch write controller       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package latch_ctrl_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb2 : combinational two-requester round-robin arbiter          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arb2
  import latch_ctrl_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last_owner,
  output logic [NREQ-1:0] gnt,
  output logic            winner
);

  always_comb begin
    gnt    = '0;
    winner = 1'b0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        winner = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        winner = 1'b1;
      end
      2'b11: begin
        // On contention the requester that did not win last time goes next
        winner = ~last_owner;
        gnt    = last_owner ? 2'b01 : 2'b10;
      end
      default: begin
        gnt    = '0;
        winner = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/latch_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | latch_write_arbiter : round-robin write sequencer for a latch bank |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module latch_write_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int DEPTH       = 4,
  parameter  int OPEN_CYCLES = 2,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] lat_d,
  output logic [DEPTH-1:0] lat_en
);

  localparam int CW = 4;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_addr;
  logic             r_owner;
  logic             r_last_owner;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_lat_d;
  logic [DEPTH-1:0] r_lat_en;
  logic [NREQ-1:0]  w_arb_gnt;
  logic             w_winner;
  logic             w_start;
  logic [DEPTH-1:0] w_en_sel;
  logic             w_addr_ok;

  rr_arb2 u_arb (
    .req        (req),
    .last_owner (r_last_owner),
    .gnt        (w_arb_gnt),
    .winner     (w_winner)
  );

  assign w_start = (r_state == IDLE) && (req != '0);

  // An out-of-range address matches no entry, so no enable is ever raised
  always_comb begin
    w_en_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_en_sel[i] = (r_addr == AW'(i));
    end
  end

  assign w_addr_ok = |w_en_sel;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = OPEN;
      OPEN:    if (r_cnt == '0) w_state_nxt = HOLD;
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_lat_d doubles as the captured data register: it only loads on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
      r_lat_d      <= '0;
      r_lat_en     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_addr       <= w_winner ? addr1  : addr0;
        r_lat_d      <= w_winner ? wdata1 : wdata0;
        r_owner      <= w_winner;
        r_last_owner <= w_winner;
      end
      if (r_state == SETUP) begin
        r_cnt <= CW'(OPEN_CYCLES - 1);
      end else if ((r_state == OPEN) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_lat_en <= (w_state_nxt == OPEN) ? w_en_sel : '0;
    end
  end

  assign gnt    = w_start ? w_arb_gnt : '0;
  assign busy   = (r_state != IDLE);
  assign done   = (r_state == HOLD) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign err    = (r_state == HOLD) && !w_addr_ok;
  assign lat_d  = r_lat_d;
  assign lat_en = r_lat_en;

endmodule
`default_nettype wire

// File: tb/tb_latch_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_latch_write_arbiter : directed bench, DEPTH=4 and DEPTH=3 DUTs  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_latch_write_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;

  logic [1:0] gnt, done, gnt3, done3;
  logic       err, busy, err3, busy3;
  logic [7:0] lat_d, lat_d3;
  logic [3:0] lat_en;
  logic [2:0] lat_en3;

  int total = 0;
  int bad   = 0;

  logic [7:0] p_d, p_d3;
  logic [3:0] p_en;
  logic [2:0] p_en3;

  latch_write_arbiter #(.WIDTH(8), .DEPTH(4), .OPEN_CYCLES(2)) dut (
    .clk (clk), .reset (reset), .req (req),
    .addr0 (addr0), .addr1 (addr1), .wdata0 (wdata0), .wdata1 (wdata1),
    .gnt (gnt), .done (done), .err (err), .busy (busy),
    .lat_d (lat_d), .lat_en (lat_en)
  );

  latch_write_arbiter #(.WIDTH(8), .DEPTH(3), .OPEN_CYCLES(2)) dut3 (
    .clk (clk), .reset (reset), .req (req),
    .addr0 (addr0), .addr1 (addr1), .wdata0 (wdata0), .wdata1 (wdata1),
    .gnt (gnt3), .done (done3), .err (err3), .busy (busy3),
    .lat_d (lat_d3), .lat_en (lat_en3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then check the bus-stability and one-hot invariants
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      if ((p_en != 0) || (lat_en != 0)) check("lat_d_stable", lat_d, p_d);
      if ((p_en3 != 0) || (lat_en3 != 0)) check("lat_d3_stable", lat_d3, p_d3);
      check("en_onehot", ($countones(lat_en) <= 1), 1);
      check("en3_onehot", ($countones(lat_en3) <= 1), 1);
      p_en  = lat_en;
      p_en3 = lat_en3;
    end else begin
      p_en  = '0;
      p_en3 = '0;
    end
    p_d  = lat_d;
    p_d3 = lat_d3;
  endtask

  initial begin
    reset  = 1'b0;
    req    = 2'b00;
    addr0  = '0;
    addr1  = '0;
    wdata0 = '0;
    wdata1 = '0;
    p_d = '0; p_d3 = '0; p_en = '0; p_en3 = '0;

    // Reset values
    tick();
    check("rst_outs", {gnt, done, err, busy, lat_d, lat_en}, 0);
    check("rst_outs3", {gnt3, done3, err3, busy3, lat_d3, lat_en3}, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_outs", {gnt, done, err, busy, lat_d, lat_en}, 0);
    end
    reset = 1'b0;
    tick();
    check("pulse_outs", {gnt, done, err, busy, lat_d, lat_en}, 0);
    reset = 1'b1;

    // Continuous contention: 01, 10, 01 at 5-cycle spacing
    req = 2'b11; addr0 = 2'd1; addr1 = 2'd3; wdata0 = 8'h11; wdata1 = 8'h33;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rr_gnt", gnt, (k == 1) ? 2'b10 : 2'b01);
      check("rr_gnt3", gnt3, (k == 1) ? 2'b10 : 2'b01);
      tick();
      if (k == 2) req = 2'b00;
      check("rr_setup_d", lat_d, (k == 1) ? 8'h33 : 8'h11);
      check("rr_setup_en", lat_en, 0);
      check("rr_setup_busy", {busy, gnt}, 3'b100);
      tick();
      check("rr_open1_en", lat_en, (k == 1) ? 4'b1000 : 4'b0010);
      check("rr_open1_en3", lat_en3, (k == 1) ? 3'b000 : 3'b010);
      tick();
      check("rr_open2_en", lat_en, (k == 1) ? 4'b1000 : 4'b0010);
      check("rr_open2_done", done, 0);
      tick();
      check("rr_hold_done", {done, err, lat_en}, (k == 1) ? 7'b10_0_0000 : 7'b01_0_0000);
      check("rr_hold_done3", {done3, err3, lat_en3}, (k == 1) ? 6'b10_1_000 : 6'b01_0_000);
      tick();
    end
    check("rr_end_idle", {busy, gnt}, 3'b000);

    // Single write: addr0=2, data A5
    req = 2'b01; addr0 = 2'd2; wdata0 = 8'hA5;
    #1;
    check("w_gnt", {gnt, busy}, 3'b010);
    tick();
    req = 2'b00;
    check("w_setup", {busy, lat_d, lat_en}, {1'b1, 8'hA5, 4'b0000});
    tick();
    check("w_open1", {lat_d, lat_en}, {8'hA5, 4'b0100});
    tick();
    check("w_open2", {lat_d, lat_en, done}, {8'hA5, 4'b0100, 2'b00});
    tick();
    check("w_hold", {busy, done, err, lat_d, lat_en}, {1'b1, 2'b01, 1'b0, 8'hA5, 4'b0000});
    tick();
    check("w_idle", {busy, done, lat_d}, {1'b0, 2'b00, 8'hA5});

    // Address 3 is out of range for the DEPTH=3 instance
    req = 2'b10; addr1 = 2'd3; wdata1 = 8'hC3;
    #1;
    check("oor_gnt3", gnt3, 2'b10);
    tick();
    req = 2'b00;
    tick();
    check("oor_open1", {lat_en3, lat_en}, {3'b000, 4'b1000});
    tick();
    check("oor_open2", lat_en3, 0);
    tick();
    check("oor_hold3", {done3, err3, lat_en3}, {2'b10, 1'b1, 3'b000});
    check("oor_hold4", {done, err}, {2'b10, 1'b0});
    tick();
    check("oor_idle3", {done3, err3, busy3}, 0);

    // Reset during the first OPEN cycle
    req = 2'b01; addr0 = 2'd2; wdata0 = 8'h5A;
    #1;
    check("mr_gnt", gnt, 2'b01);
    tick();
    req = 2'b00;
    tick();
    check("mr_open", lat_en, 4'b0100);
    #2;
    reset = 1'b0;
    #1;
    check("mr_async_en", {lat_en, lat_en3, busy}, 0);
    tick();
    check("mr_no_done", {done, done3, err, busy, lat_d}, 0);
    reset = 1'b1;
    req = 2'b01; addr0 = 2'd1; wdata0 = 8'h77;
    #1;
    check("mr_regnt", gnt, 2'b01);
    tick();
    req = 2'b00;
    check("mr_setup", {lat_d, done}, {8'h77, 2'b00});
    tick();
    check("mr_open", {lat_en, done}, {4'b0010, 2'b00});
    tick();
    tick();
    check("mr_hold", {done, err}, {2'b01, 1'b0});
    tick();
    check("mr_idle", {busy, done}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/latch_write_arbiter.md
# latch_write_arbiter

Write controller that shares a bank of DEPTH level-sensitive D latches between two requesters. It arbitrates round-robin between the requesters and captures the winner's address and data. It then sequences each latch write through setup, open-enable and hold phases, so latch data never changes while an enable is high. It sits between the lab's requester logic and the latch bank; it drives the bank's shared data bus and per-entry enables.

## Interface
- WIDTH, 8, data width of each latch entry and of the shared data bus
- DEPTH, 4, number of latch entries; address width AW = $clog2(DEPTH)
- OPEN_CYCLES, 2, cycles the selected latch enable is held high; legal range 1..15
- clk  in  1  single system clock, rising-edge
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately
- req  in  2  per-requester write request, level; held until the matching gnt bit is seen
- addr0, addr1  in  AW each  target entry for requester 0 / 1; stable while req is high
- wdata0, wdata1  in  WIDTH each  write data for requester 0 / 1; stable while req is high
- gnt  out  2  one-hot accept strobe, one cycle; inputs are sampled on that edge
- done  out  2  one-hot completion strobe to the owning requester, one cycle
- err  out  1  one-cycle strobe with done when the captured addr >= DEPTH
- busy  out  1  high in every state except IDLE
- lat_d  out  WIDTH  shared latch data bus, registered
- lat_en  out  DEPTH  per-entry latch enable, registered, at most one bit high

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD.
- IDLE: if req != 0, assert gnt for the winner (combinational in this cycle), then on the clock edge capture addr/wdata into addr_q/data_q, record owner, and go to SETUP. If req == 0, stay in IDLE.
- Arbitration: a single requester wins. If both request, the winner is the one not equal to last_owner. last_owner updates on every grant; its reset value is 1, so requester 0 wins the first contention.
- SETUP (1 cycle): lat_d = data_q, lat_en = 0.
- OPEN (OPEN_CYCLES cycles): lat_en[addr_q] = 1 and lat_d = data_q. A down-counter loaded with OPEN_CYCLES-1 on entry sets the length. If addr_q >= DEPTH, lat_en stays 0 but timing is unchanged.
- HOLD (1 cycle): lat_en = 0, lat_d still data_q. done[owner] = 1, and err = 1 if addr_q >= DEPTH. Next state is IDLE.
- lat_d keeps its last value in IDLE; it changes only on the IDLE->SETUP edge.
- A req still high after its gnt is treated as a new request at the next IDLE.
- Reset values: state IDLE, gnt 0, done 0, err 0, busy 0, lat_d 0, lat_en 0, last_owner 1, counter 0.
- Reset asserted mid-write: lat_en drops to 0 asynchronously, no done is issued, and the interrupted write is lost.

## Timing
- gnt at cycle T (accept edge end of T).
- SETUP is cycle T+1.
- OPEN spans T+2 .. T+1+OPEN_CYCLES.
- HOLD and done are at T+2+OPEN_CYCLES.
- Next earliest gnt is at T+3+OPEN_CYCLES, so with OPEN_CYCLES=2 the throughput is one write per 5 cycles.
- busy is high from T+1 through T+2+OPEN_CYCLES inclusive.
- lat_d is stable at least 1 cycle before the rising edge of lat_en and at least 1 cycle after its falling edge.

## Structure
- Package latch_ctrl_pkg holds the state enum typedef (IDLE, SETUP, OPEN, HOLD) and the requester-count constant NREQ = 2.
- Sub-module rr_arb2 is a two-requester round-robin arbiter with inputs req[1:0] and last_owner, and outputs a one-hot grant and a winner index. It is purely combinational; the last_owner register lives in the parent.
- Everything else (FSM, counter, capture registers, output registers) lives in latch_write_arbiter.

## Test plan
- Reset low then high, no req: all outputs 0 and busy 0 for 10 cycles. Assert reset low for 1 cycle and check everything stays at reset values.
- req=01, addr0=2, wdata0=0xA5, OPEN_CYCLES=2: gnt=01 at T, lat_en=0100 at T+2..T+3, lat_d=0xA5 from T+1 to T+4, done=01 at T+4.
- req=11 held continuously, addr0=1, addr1=3: grants alternate 01, 10, 01, each spaced 5 cycles, with lat_en=0010 / 1000 in the matching OPEN windows.
- DEPTH=3, addr1=3: lat_en stays 000 throughout, done=10 and err=1 at T+4.
- Reset pulled low during the first OPEN cycle: lat_en goes to 0 before the next clk edge and no done is issued. After release, a new req=01 is granted on the first IDLE cycle.
- Checker over all scenarios: lat_d never changes while any lat_en bit is high, and lat_en never has more than one bit set.
